// File: rtl/uart_rx_pkg.sv
// Shared FSM encoding, default divider and width helper for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // 10 MHz clock / 115200 baud, rounded
    localparam int unsigned DefaultBaudDiv = 87;

    // Bits needed to hold values 0..value-1 (minimum 1)
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; pointers carry an extra wrap bit for full/empty.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [Width-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [Width-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AddrW = clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q;
    logic [AddrW:0]   rd_ptr_q;

    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                       (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign o_rd_data = mem_q[rd_ptr_q[AddrW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (i_wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (i_rd_en && !o_empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Caller only writes when there is room (or a read frees the head slot this cycle)
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver. Default build buffers one byte; define UART_RX_FIFO_EN for a
// G_FIFO_DEPTH-entry first-word-fall-through FIFO.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned G_BAUD_DIV   = DefaultBaudDiv,
    parameter int unsigned G_FIFO_DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_framing_error,
    output logic       o_overflow,
    output logic       o_busy
);

    localparam int unsigned     CntW     = clog2(G_BAUD_DIV);
    localparam logic [CntW-1:0] HalfLoad = CntW'(G_BAUD_DIV / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(G_BAUD_DIV - 1);

    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_hist_q;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            framing_error_q;
    logic            overflow_q;
    logic            stop_write;
    logic            buf_full;
    logic            buf_read;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_hist_q <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_hist_q <= rx_sync_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            framing_error_q <= 1'b0;
        end else begin
            framing_error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Falling edge only, so a line stuck low cannot retrigger
                    if (rx_hist_q && !rx_sync_q) begin
                        state_q <= StStart;
                        cnt_q   <= HalfLoad;
                    end
                end
                StStart: begin
                    if (cnt_q == '0) begin
                        if (rx_sync_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StData;
                            cnt_q     <= FullLoad;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == '0) begin
                        shift_q[bit_idx_q] <= rx_sync_q;
                        cnt_q              <= FullLoad;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == '0) begin
                        state_q         <= StIdle;
                        framing_error_q <= !rx_sync_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stop_write = (state_q == StStop) && (cnt_q == '0) && rx_sync_q;
    assign buf_read   = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= stop_write && buf_full && !buf_read;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic       fifo_empty;
    logic [7:0] fifo_head;

    uart_rx_fifo #(
        .Depth (G_FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (stop_write && (!buf_full || buf_read)),
        .i_wr_data (shift_q),
        .i_rd_en   (buf_read),
        .o_rd_data (fifo_head),
        .o_full    (buf_full),
        .o_empty   (fifo_empty)
    );

    assign o_valid = !fifo_empty;
    assign o_data  = fifo_empty ? 8'h00 : fifo_head;
`else
    logic       hold_valid_q;
    logic [7:0] hold_data_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
        end else if (stop_write && (!hold_valid_q || buf_read)) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= shift_q;
        end else if (buf_read) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign buf_full = hold_valid_q;
    assign o_valid  = hold_valid_q;
    assign o_data   = hold_data_q;
`endif

    assign o_framing_error = framing_error_q;
    assign o_overflow      = overflow_q;
    assign o_busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: random 8N1 frames against a queue-based model of the buffer.
module tb_uart_rx;

    localparam int Div   = 87;
    localparam int Depth = 16;
`ifdef UART_RX_FIFO_EN
    localparam int Cap = Depth;
`else
    localparam int Cap = 1;
`endif
    // Stop-bit sample edge after the line falls: 2-flop sync, half bit, then 9 full bits
    localparam int StopEdge = 2 + Div / 2 + 9 * Div;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_framing_error;
    logic       o_overflow;
    logic       o_busy;

    uart_rx #(
        .G_BAUD_DIV   (Div),
        .G_FIFO_DEPTH (Depth)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_uart_rx       (rx),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .i_ready         (ready),
        .o_framing_error (o_framing_error),
        .o_overflow      (o_overflow),
        .o_busy          (o_busy)
    );

    initial forever #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovf = 0;
    int         ferr_seen = 0;
    int         ovf_seen = 0;
    logic       ready_rand = 1'b0;
    logic       ready_force = 1'b0;
    logic       hold_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Consumer: random or forced ready, changed only on falling edges
    initial forever begin
        @(negedge clk);
        ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Monitor: what is seen here is what the next rising edge acts on
    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (o_framing_error) ferr_seen++;
            if (o_overflow) ovf_seen++;
            if (hold_prev && o_valid) check("data_stable", 32'(o_data), 32'(data_prev));
            if (o_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_byte: got 0x%02h, expected no byte", o_data);
                end else begin
                    check("rx_byte", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
            hold_prev = o_valid && !ready;
            data_prev = o_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference model: good frames land in the buffer unless it is full and nobody reads
    task automatic issue(input logic [7:0] b, input logic good, input logic rd_at_stop);
        if (!good) exp_ferr++;
        else if (ready_rand || ready_force || rd_at_stop || exp_q.size() < Cap) exp_q.push_back(b);
        else exp_ovf++;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (Div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == abort_bit) begin
                repeat (Div / 2) @(negedge clk);
                return;
            end
            repeat (Div) @(negedge clk);
        end
        rx = stop_bit;
        repeat (Div) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4 * Div) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 0);
        check({tag, "_data"}, 32'(o_data), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_ferr"}, 32'(o_framing_error), 0);
        check({tag, "_ovf"}, 32'(o_overflow), 0);
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        idle(10);

        // Single byte, consumer always ready: latency and one-cycle valid
        ready_force = 1'b1;
        idle(2);
        issue(8'h41, 1'b1, 1'b0);
        fork
            send_frame(8'h41, 1'b1, 8);
            begin
                int k;
                k = 0;
                @(negedge clk);
                while (k < 3 * StopEdge) begin
                    @(negedge clk);
                    #1;
                    k++;
                    if (k == 400) check("busy_mid_frame", 32'(o_busy), 1);
                    if (o_valid) break;
                end
                check("valid_latency", 32'(k), 32'(StopEdge + 1));
                @(negedge clk);
                #1;
                check("valid_one_cycle", 32'(o_valid), 0);
            end
        join
        idle(20);
        check("ferr_after_41", 32'(ferr_seen), 32'(exp_ferr));

        // Short low glitch: false start, no output
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        #1;
        check("busy_in_glitch", 32'(o_busy), 1);
        idle(Div);
        #1;
        check("idle_after_glitch", 32'(o_busy), 0);
        check("ferr_after_glitch", 32'(ferr_seen), 32'(exp_ferr));

        // Bad stop bit, then a good frame
        issue(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 8);
        idle(6);
        issue(8'h0A, 1'b1, 1'b0);
        send_frame(8'h0A, 1'b1, 8);
        idle(10);
        check("ferr_after_55", 32'(ferr_seen), 32'(exp_ferr));
        drain("drain_0a");

        // Random frames, random consumer, occasional glitches and bad stops
        ready_force = 1'b0;
        ready_rand  = 1'b1;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            logic       good;
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) begin
                rx = 1'b0;
                idle(int'($urandom_range(2, 20)));
                rx = 1'b1;
                idle(Div);
            end
            issue(b, good, 1'b0);
            send_frame(b, good, 8);
            idle(int'($urandom_range(4, 2 * Div)));
        end
        ready_rand = 1'b0;
        ready_force = 1'b1;
        drain("drain_random");
        check("ferr_random", 32'(ferr_seen), 32'(exp_ferr));
        check("ovf_random", 32'(ovf_seen), 32'(exp_ovf));

        // Consumer stalled: Cap bytes stored, the next one overflows
        ready_force = 1'b0;
        idle(5);
        for (int k = 0; k <= Cap; k++) begin
            issue(8'(8'h31 + k), 1'b1, 1'b0);
            send_frame(8'(8'h31 + k), 1'b1, 8);
            idle(4);
        end
        #1;
        check("ovf_count", 32'(ovf_seen), 32'(exp_ovf));
        check("held_valid", 32'(o_valid), 1);
        check("held_data", 32'(o_data), 32'h31);
        ready_force = 1'b1;
        drain("drain_overflow");

        // Full buffer read on the very cycle of the stop-bit write: no overflow
        ready_force = 1'b0;
        idle(5);
        for (int k = 0; k < Cap; k++) begin
            issue(8'(8'h60 + k), 1'b1, 1'b0);
            send_frame(8'(8'h60 + k), 1'b1, 8);
            idle(4);
        end
        issue(8'h7E, 1'b1, 1'b1);
        fork
            send_frame(8'h7E, 1'b1, 8);
            begin
                @(negedge clk);
                repeat (StopEdge) @(posedge clk);
                ready_force = 1'b1;
                @(posedge clk);
                ready_force = 1'b0;
            end
        join
        idle(10);
        #1;
        check("ovf_simul_read", 32'(ovf_seen), 32'(exp_ovf));
        check("valid_after_simul", 32'(o_valid), 1);
        ready_force = 1'b1;
        drain("drain_simul");

        // Reset in the middle of bit 3 with a byte pending
        ready_force = 1'b0;
        idle(5);
        issue(8'hC3, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 8);
        idle(4);
        #1;
        check("pending_before_reset", 32'(o_valid), 1);
        send_frame(8'h99, 1'b1, 3);
        #1;
        check("busy_before_reset", 32'(o_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        ready_force = 1'b1;
        idle(5);
        issue(8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 8);
        drain("drain_a5");
        idle(5);
        check("ferr_total", 32'(ferr_seen), 32'(exp_ferr));
        check("ovf_total", 32'(ovf_seen), 32'(exp_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
